// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and the MEM stage.
// MEM has priority, but IF wins a tie after STARVE_LIMIT consecutive MEM wins over a waiting fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  InstrRead_IF,
  input  logic [ADDR_WIDTH-1:0] Address_IF,
  input  logic                  MemRead_MEM,
  input  logic                  MemWrite_MEM,
  input  logic [ADDR_WIDTH-1:0] Address_MEM,
  input  logic [DATA_WIDTH-1:0] WriteData_MEM,
  output logic [DATA_WIDTH-1:0] Instruction_IF,
  output logic [DATA_WIDTH-1:0] ReadData_MEM,
  output logic                  Done_IF,
  output logic                  Done_MEM,
  output logic                  Stall_IF,
  output logic                  Stall_MEM,
  output logic                  Mem_Req,
  output logic                  Mem_We,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] Mem_WData,
  input  logic [DATA_WIDTH-1:0] Mem_RData,
  input  logic                  Mem_Ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                r_state,    w_state_nxt;
  logic [3:0]            r_starve,   w_starve_nxt;
  logic                  r_req,      w_req_nxt;
  logic                  r_we,       w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,     w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,    w_wdata_nxt;
  logic [DATA_WIDTH-1:0] r_instr,    w_instr_nxt;
  logic [DATA_WIDTH-1:0] r_rdata,    w_rdata_nxt;
  logic                  r_done_if,  w_done_if_nxt;
  logic                  r_done_mem, w_done_mem_nxt;

  logic w_elig_if;
  logic w_elig_mem;
  logic w_grant_mem;
  logic w_grant_if;

  // A requester still holds its request during its own Done cycle; masking with Done prevents a re-grant.
  assign w_elig_if   = InstrRead_IF & ~r_done_if;
  assign w_elig_mem  = (MemRead_MEM | MemWrite_MEM) & ~r_done_mem;
  assign w_grant_mem = w_elig_mem & ~(w_elig_if & (r_starve == LIMIT));
  assign w_grant_if  = w_elig_if & ~w_grant_mem;

  always_comb begin
    w_state_nxt    = r_state;
    w_starve_nxt   = r_starve;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_instr_nxt    = r_instr;
    w_rdata_nxt    = r_rdata;
    w_done_if_nxt  = 1'b0;
    w_done_mem_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_mem) begin
          w_state_nxt = BUSY_MEM;
          w_req_nxt   = 1'b1;
          w_we_nxt    = MemWrite_MEM;
          w_addr_nxt  = Address_MEM;
          w_wdata_nxt = WriteData_MEM;
          if (w_elig_if && (r_starve < LIMIT)) begin
            w_starve_nxt = r_starve + 4'd1;
          end
        end else if (w_grant_if) begin
          w_state_nxt  = BUSY_IF;
          w_req_nxt    = 1'b1;
          w_we_nxt     = 1'b0;
          w_addr_nxt   = Address_IF;
          w_starve_nxt = '0;
        end
      end
      BUSY_IF: begin
        if (Mem_Ready) begin
          w_state_nxt   = IDLE;
          w_req_nxt     = 1'b0;
          w_we_nxt      = 1'b0;
          w_done_if_nxt = 1'b1;
          w_instr_nxt   = Mem_RData;
        end
      end
      BUSY_MEM: begin
        if (Mem_Ready) begin
          w_state_nxt    = IDLE;
          w_req_nxt      = 1'b0;
          w_we_nxt       = 1'b0;
          w_done_mem_nxt = 1'b1;
          if (!r_we) begin
            w_rdata_nxt = Mem_RData;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_starve   <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_instr    <= '0;
      r_rdata    <= '0;
      r_done_if  <= 1'b0;
      r_done_mem <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_starve   <= w_starve_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_instr    <= w_instr_nxt;
      r_rdata    <= w_rdata_nxt;
      r_done_if  <= w_done_if_nxt;
      r_done_mem <= w_done_mem_nxt;
    end
  end

  assign Instruction_IF = r_instr;
  assign ReadData_MEM   = r_rdata;
  assign Done_IF        = r_done_if;
  assign Done_MEM       = r_done_mem;
  assign Mem_Req        = r_req;
  assign Mem_We         = r_we;
  assign Mem_Addr       = r_addr;
  assign Mem_WData      = r_wdata;
  assign Stall_IF       = InstrRead_IF & ~r_done_if;
  assign Stall_MEM      = (MemRead_MEM | MemWrite_MEM) & ~r_done_mem;

endmodule
